// File: rtl/pcie_dma_multichan_seq.sv
// Multi-channel DMA write sequencer: per-channel base/count programming, round-robin
// TLP write requests of TLP_BYTES each, and a per-channel MSI request on completion.
module pcie_dma_multichan_seq #(
  parameter int NUM_CHAN     = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int TLP_BYTES    = 128,
  parameter int COUNT_WIDTH  = 8,
  parameter int MSI_VEC_LOG2 = 1,
  localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
  localparam int MW = (MSI_VEC_LOG2 > 0) ? MSI_VEC_LOG2 : 1
) (
  input  logic                  clk_in,
  input  logic                  rstn,
  input  logic                  reg_wr_valid,
  input  logic [CW-1:0]         reg_wr_chan,
  input  logic                  reg_wr_sel,
  input  logic [31:0]           reg_wr_data,
  output logic                  tlp_valid,
  input  logic                  tlp_ready,
  output logic [ADDR_WIDTH-1:0] tlp_addr,
  output logic [CW-1:0]         tlp_chan,
  output logic                  tlp_last,
  output logic                  msi_req,
  output logic [MW-1:0]         msi_num,
  input  logic                  msi_ack,
  output logic [NUM_CHAN-1:0]   chan_busy,
  output logic [NUM_CHAN-1:0]   err_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_XFER     = 2'd1,
    ST_MSI_WAIT = 2'd2
  } chan_state_t;

  logic                   tlp_valid_reg;
  logic [ADDR_WIDTH-1:0]  tlp_addr_reg;
  logic [CW-1:0]          tlp_chan_reg;
  logic                   tlp_last_reg;
  logic                   msi_req_reg;
  logic [CW-1:0]          msi_chan_reg;
  logic [MW-1:0]          msi_num_reg;
  logic [CW-1:0]          rr_ptr_reg;

  logic                   tlp_acc;
  logic                   msi_take;
  logic [COUNT_WIDTH-1:0] wr_count;
  logic                   unused_wr_data;

  // Per-channel view of "what this channel would present next", already
  // accounting for a start or an accept happening in the current cycle.
  logic [ADDR_WIDTH-1:0]  la_addr [NUM_CHAN];
  logic [COUNT_WIDTH-1:0] la_rem  [NUM_CHAN];
  logic [NUM_CHAN-1:0]    la_elig;
  logic [NUM_CHAN-1:0]    msi_elig;
  logic [NUM_CHAN-1:0]    busy_vec;
  logic [NUM_CHAN-1:0]    err_vec;

  assign tlp_acc        = tlp_valid_reg & tlp_ready;
  assign msi_take       = msi_req_reg & msi_ack;
  assign wr_count       = reg_wr_data[COUNT_WIDTH-1:0];
  assign unused_wr_data = ^reg_wr_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
      chan_state_t            state_reg;
      chan_state_t            state_next;
      logic [ADDR_WIDTH-1:0]  base_reg;
      logic [ADDR_WIDTH-1:0]  addr_reg;
      logic [COUNT_WIDTH-1:0] rem_reg;
      logic                   err_reg;
      logic                   busy_flag;
      logic                   wr_hit;
      logic                   base_wr;
      logic                   ctrl_start;
      logic                   acc_hit;
      logic                   acc_last;
      logic                   ack_hit;

      assign wr_hit     = reg_wr_valid && (reg_wr_chan == CW'(gi));
      assign base_wr    = wr_hit && !reg_wr_sel && (state_reg == ST_IDLE);
      assign ctrl_start = wr_hit && reg_wr_sel && (state_reg == ST_IDLE) && (wr_count != '0);
      assign acc_hit    = tlp_acc && (tlp_chan_reg == CW'(gi));
      assign acc_last   = acc_hit && (rem_reg == COUNT_WIDTH'(1));
      assign ack_hit    = msi_take && (msi_chan_reg == CW'(gi));

      always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
      end

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          ST_IDLE:     if (ctrl_start) state_next = ST_XFER;
          ST_XFER:     if (acc_last)   state_next = ST_MSI_WAIT;
          ST_MSI_WAIT: if (ack_hit)    state_next = ST_IDLE;
          default:     state_next = ST_IDLE;
        endcase
      end

      always_comb begin
        busy_flag = (state_reg != ST_IDLE);
      end

      always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
          base_reg <= '0;
          addr_reg <= '0;
          rem_reg  <= '0;
          err_reg  <= 1'b0;
        end else begin
          if (base_wr)
            base_reg <= {reg_wr_data[ADDR_WIDTH-1:3], 3'b000};
          if (ctrl_start) begin
            addr_reg <= base_reg;
            rem_reg  <= wr_count;
          end else if (acc_hit) begin
            addr_reg <= addr_reg + ADDR_WIDTH'(TLP_BYTES);
            rem_reg  <= rem_reg - COUNT_WIDTH'(1);
          end
          if (wr_hit && (state_reg != ST_IDLE))
            err_reg <= 1'b1;
        end
      end

      assign la_addr[gi]  = ctrl_start ? base_reg :
                            (acc_hit ? addr_reg + ADDR_WIDTH'(TLP_BYTES) : addr_reg);
      assign la_rem[gi]   = ctrl_start ? wr_count :
                            (acc_hit ? rem_reg - COUNT_WIDTH'(1) : rem_reg);
      assign la_elig[gi]  = ctrl_start || ((state_reg == ST_XFER) && !acc_last);
      assign msi_elig[gi] = ((state_reg == ST_MSI_WAIT) && !ack_hit) || acc_last;
      assign busy_vec[gi] = busy_flag;
      assign err_vec[gi]  = err_reg;
    end
  endgenerate

  // Round-robin search starts from the pointer as it will be after this cycle's accept.
  logic [CW-1:0] rr_base;
  logic [CW-1:0] rr_cand;
  logic [CW-1:0] rr_sel;
  logic          rr_found;
  int            rr_idx;

  always_comb begin
    rr_base = rr_ptr_reg;
    if (tlp_acc)
      rr_base = (tlp_chan_reg == CW'(NUM_CHAN - 1)) ? '0 : tlp_chan_reg + CW'(1);
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = 0;
    rr_cand  = '0;
    for (int k = 0; k < NUM_CHAN; k++) begin
      rr_idx = int'(rr_base) + k;
      if (rr_idx >= NUM_CHAN)
        rr_idx = rr_idx - NUM_CHAN;
      rr_cand = CW'(rr_idx);
      if (!rr_found && la_elig[rr_cand]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      tlp_valid_reg <= 1'b0;
      tlp_addr_reg  <= '0;
      tlp_chan_reg  <= '0;
      tlp_last_reg  <= 1'b0;
      rr_ptr_reg    <= '0;
    end else begin
      if (tlp_acc)
        rr_ptr_reg <= rr_base;
      if (!tlp_valid_reg || tlp_acc) begin
        tlp_valid_reg <= rr_found;
        if (rr_found) begin
          tlp_addr_reg <= la_addr[rr_sel];
          tlp_chan_reg <= rr_sel;
          tlp_last_reg <= (la_rem[rr_sel] == COUNT_WIDTH'(1));
        end
      end
    end
  end

  // Lowest-index channel awaiting an interrupt wins the single MSI slot.
  logic [CW-1:0] msi_sel;
  logic          msi_found;

  always_comb begin
    msi_found = 1'b0;
    msi_sel   = '0;
    for (int k = NUM_CHAN - 1; k >= 0; k--) begin
      if (msi_elig[k]) begin
        msi_found = 1'b1;
        msi_sel   = CW'(k);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      msi_req_reg  <= 1'b0;
      msi_chan_reg <= '0;
      msi_num_reg  <= '0;
    end else if (!msi_req_reg || msi_take) begin
      msi_req_reg <= msi_found;
      if (msi_found) begin
        msi_chan_reg <= msi_sel;
        msi_num_reg  <= MW'(int'(msi_sel) % (1 << MSI_VEC_LOG2));
      end
    end
  end

  assign tlp_valid  = tlp_valid_reg;
  assign tlp_addr   = tlp_addr_reg;
  assign tlp_chan   = tlp_chan_reg;
  assign tlp_last   = tlp_last_reg;
  assign msi_req    = msi_req_reg;
  assign msi_num    = msi_num_reg;
  assign chan_busy  = busy_vec;
  assign err_sticky = err_vec;

endmodule

// File: doc/pcie_dma_multichan_seq.md
Name: pcie_dma_multichan_seq

Overview:
- Synthesisable FPGA-side DMA write sequencer with NUM_CHAN independent channels.
- Host programs each channel through per-channel DMABASE/DMACTRL registers. The block emits one TLP-write request per TLP_BYTES chunk, round-robin interleaved across channels.
- When a channel finishes, the block raises a per-channel MSI request.
- Sits between the BAR register decoder and the TLP transmit formatter/MSI generator.
- Generalises the single-channel, count-of-1 DMA engine to multi-TLP transfers, multiple channels and multiple MSI vectors.

Parameters:
- NUM_CHAN, 2, number of DMA channels (1..8).
- ADDR_WIDTH, 32, RC byte-address width (8..32).
- TLP_BYTES, 128, payload bytes per TLP; power of two, 8..512.
- COUNT_WIDTH, 8, width of TLP-count field in DMACTRL.
- MSI_VEC_LOG2, 1, log2 of MSI vectors enabled (0..5).

Ports:
- clk_in  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- reg_wr_valid  in  1  register write strobe, one cycle.
- reg_wr_chan  in  max(1,$clog2(NUM_CHAN))  target channel.
- reg_wr_sel  in  1  0=DMABASE, 1=DMACTRL.
- reg_wr_data  in  32  write data.
- tlp_valid  out  1  TLP write request valid.
- tlp_ready  in  1  formatter accepts request.
- tlp_addr  out  ADDR_WIDTH  RC byte address of this TLP.
- tlp_chan  out  max(1,$clog2(NUM_CHAN))  originating channel.
- tlp_last  out  1  final TLP of this channel's transfer.
- msi_req  out  1  MSI request.
- msi_num  out  MSI_VEC_LOG2 (min 1)  vector number = channel mod 2^MSI_VEC_LOG2.
- msi_ack  in  1  MSI generator consumed request.
- chan_busy  out  NUM_CHAN  per-channel busy flags.
- err_sticky  out  NUM_CHAN  per-channel write-while-busy error, sticky until reset.

Behaviour:
- Reset values:
  - All outputs 0.
  - Per-channel state: base=0, remaining=0, IDLE.
  - Round-robin pointer=0.
  - Reset mid-transfer or mid-MSI immediately drops tlp_valid/msi_req; nothing resumes.
- Per-channel FSM: IDLE -> XFER -> MSI_WAIT -> IDLE.
- DMABASE write (sel=0):
  - In IDLE: base <= reg_wr_data[ADDR_WIDTH-1:0] with bits [2:0] forced 0.
  - In any other state: ignored, err_sticky[chan] set.
- DMACTRL write (sel=1), count = reg_wr_data[COUNT_WIDTH-1:0]:
  - In IDLE with count!=0: remaining <= count, next_addr <= base, state XFER, chan_busy set on the following edge.
  - count==0: no TLP, no MSI, stays IDLE.
  - In XFER or MSI_WAIT: ignored, err_sticky set.
- Request presentation:
  - tlp_* are registered and change only when tlp_valid=0 or (tlp_valid & tlp_ready).
  - Contents are held stable while valid & !ready.
  - Earliest tlp_valid is the cycle after the DMACTRL write.
  - Back-to-back is allowed: after an accept edge, the next request (any channel) may be valid in the next cycle, giving full throughput.
- Arbitration:
  - Among channels in XFER, search round-robin starting at pointer.
  - After channel c is accepted, pointer <= (c+1) mod NUM_CHAN.
  - A channel never has two outstanding requests.
- On accept of a request for channel c:
  - next_addr += TLP_BYTES, modulo 2^ADDR_WIDTH; wrap-around is silent.
  - remaining -= 1.
  - tlp_last=1 when remaining was 1; state then goes to MSI_WAIT.
- MSI:
  - At most one msi_req is outstanding.
  - Among channels in MSI_WAIT, the lowest index wins.
  - msi_req asserts the cycle after the final TLP is accepted, at the earliest.
  - msi_req and msi_num are held until msi_ack.
  - On the msi_ack edge: the channel goes to IDLE, chan_busy clears, and msi_req drops (or presents the next pending channel the following cycle).
  - msi_ack without msi_req is ignored.
- Simultaneous events:
  - A register write to channel A in the same cycle as accept/ack for channel B: both take effect.
  - A write to a channel in the same cycle as that channel's msi_ack sees MSI_WAIT, so it is ignored and err_sticky is set.

Test Plan:
- Single transfer, tlp_ready=1: write DMABASE ch0=0x20, DMACTRL=1 -> exactly one request (addr 0x20, chan 0, last 1) in the cycle after the write; msi_req with msi_num 0 in the next cycle; busy clears on msi_ack.
- Interleave: ch0 base 0x1000 count 3, ch1 base 0x8000 count 2, ready=1 -> order 0x1000(c0), 0x8000(c1), 0x1080(c0), 0x8080(c1,last), 0x1100(c0,last); MSIs ch1 then ch0 (msi_num 1 then 0).
- Backpressure: ready low for 5 cycles mid-transfer -> tlp_addr/chan/last stable throughout; no lost or duplicated addresses.
- Busy write: DMABASE=0x40 to ch0 during XFER -> addresses unchanged, err_sticky[0]=1; DMACTRL count=0 -> no request, no MSI.
- Wrap: ADDR_WIDTH=16, base 0xFF80, count 2 -> addresses 0xFF80 then 0x0000.
- Reset: rstn low during MSI_WAIT -> msi_req, chan_busy, tlp_valid all 0 immediately; new DMACTRL after release restarts from base 0.
